// File: rtl/wave_gen_dds_if.sv
// Configuration handshake bundle for wave_gen_dds: a sender offers a full
// waveform setting with cfg_valid and the generator accepts it with cfg_ready.
`timescale 1ns/1ps

interface wave_gen_dds_if #(
   parameter int DATA_W  = 8,
   parameter int PHASE_W = 32,
   parameter int ADDR_W  = 11
);
   logic               cfg_valid;
   logic               cfg_ready;
   logic [1:0]         cfg_mode;
   logic [PHASE_W-1:0] cfg_ftw;
   logic [ADDR_W-1:0]  cfg_duty;
   logic [DATA_W-1:0]  cfg_amp;

   modport master (
      output cfg_valid, cfg_mode, cfg_ftw, cfg_duty, cfg_amp,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_mode, cfg_ftw, cfg_duty, cfg_amp,
      output cfg_ready
   );
endinterface

// File: rtl/wave_gen_dds.sv
// DDS waveform generator: phase accumulator -> arithmetic waveform stage -> amplitude
// scaling, with a one-deep shadow config that swaps in glitch-free on a phase wrap.
`timescale 1ns/1ps

module wave_gen_dds #(
   parameter int DATA_W  = 8,
   parameter int PHASE_W = 32,
   parameter int ADDR_W  = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ce,
   input  logic              sync_clr,
   wave_gen_dds_if.slave     cfg_bus,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              wrap
);

   localparam logic [PHASE_W-1:0] DEF_FTW  = PHASE_W'(1) << (PHASE_W - ADDR_W);
   localparam logic [ADDR_W-1:0]  DEF_DUTY = ADDR_W'(625);

   typedef enum logic {CFG_EMPTY, CFG_PENDING} cfg_state_t;

   cfg_state_t         state, state_nxt;
   logic               ready, capture, apply, apply_cond;

   logic [1:0]         sh_mode,  act_mode;
   logic [PHASE_W-1:0] sh_ftw,   act_ftw;
   logic [ADDR_W-1:0]  sh_duty,  act_duty;
   logic [DATA_W-1:0]  sh_amp,   act_amp;

   logic [PHASE_W-1:0] phase;
   logic [PHASE_W:0]   phase_sum;
   logic               carry, wrap_p;
   logic [ADDR_W-1:0]  idx;
   logic [DATA_W-1:0]  raw, raw_r, amp_r;
   logic [DATA_W:0]    amp_p1;
   logic               wrap_r, valid_r;

   assign phase_sum  = {1'b0, phase} + {1'b0, act_ftw};
   assign carry      = phase_sum[PHASE_W];
   assign idx        = phase[PHASE_W-1 -: ADDR_W];
   // A stalled accumulator (ftw=0) never wraps, so it must not block a pending swap.
   assign apply_cond = ce && (carry || sync_clr || (act_ftw == '0));
   assign cfg_bus.cfg_ready = ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= CFG_EMPTY;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         CFG_EMPTY:   if (cfg_bus.cfg_valid) state_nxt = CFG_PENDING;
         CFG_PENDING: if (apply_cond)        state_nxt = CFG_EMPTY;
         default:     state_nxt = CFG_EMPTY;
      endcase
   end

   always_comb begin
      ready   = 1'b0;
      capture = 1'b0;
      apply   = 1'b0;
      unique case (state)
         CFG_EMPTY: begin
            ready   = 1'b1;
            capture = cfg_bus.cfg_valid;
         end
         CFG_PENDING: apply = apply_cond;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_mode <= '0;
         sh_ftw  <= '0;
         sh_duty <= '0;
         sh_amp  <= '0;
      end else if (capture) begin
         sh_mode <= cfg_bus.cfg_mode;
         sh_ftw  <= cfg_bus.cfg_ftw;
         sh_duty <= cfg_bus.cfg_duty;
         sh_amp  <= cfg_bus.cfg_amp;
      end
   end

   // The active set changes on the same edge that produces the first phase it governs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         act_mode <= 2'd0;
         act_ftw  <= DEF_FTW;
         act_duty <= DEF_DUTY;
         act_amp  <= '1;
      end else if (apply) begin
         act_mode <= sh_mode;
         act_ftw  <= sh_ftw;
         act_duty <= sh_duty;
         act_amp  <= sh_amp;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase  <= '0;
         wrap_p <= 1'b0;
      end else if (ce) begin
         phase  <= sync_clr ? '0 : phase_sum[PHASE_W-1:0];
         wrap_p <= carry | sync_clr;
      end
   end

   // Triangle folds the upper index half back down; ADDR_W must be at least DATA_W+1.
   always_comb begin
      raw = '0;
      unique case (act_mode)
         2'd0:    raw = (idx < act_duty) ? '1 : '0;
         2'd1:    raw = idx[ADDR_W-1 -: DATA_W];
         2'd2:    raw = idx[ADDR_W-1] ? ~idx[ADDR_W-2 -: DATA_W] : idx[ADDR_W-2 -: DATA_W];
         2'd3:    raw = '1;
         default: raw = '0;
      endcase
   end

   assign amp_p1 = {1'b0, amp_r} + {{DATA_W{1'b0}}, 1'b1};

   // Amplitude travels with its raw sample so a config swap never mixes two settings.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         raw_r      <= '0;
         amp_r      <= '0;
         wrap_r     <= 1'b0;
         valid_r    <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
         wrap       <= 1'b0;
      end else if (ce) begin
         raw_r      <= raw;
         amp_r      <= act_amp;
         wrap_r     <= wrap_p;
         valid_r    <= 1'b1;
         dout       <= DATA_W'(({{(DATA_W+1){1'b0}}, raw_r} * {{DATA_W{1'b0}}, amp_p1}) >> DATA_W);
         dout_valid <= valid_r;
         wrap       <= wrap_r;
      end else begin
         wrap       <= 1'b0;
      end
   end

endmodule
